// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct3 values, ALU control codes,
// memory access sizes and the decoded control bundle carried into ID/EX.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0, ALU_SUB  = 4'h1, ALU_XOR = 4'h2, ALU_OR    = 4'h3,
    ALU_AND   = 4'h4, ALU_SLL  = 4'h5, ALU_SRL = 4'h6, ALU_BEQ   = 4'h7,
    ALU_BNE   = 4'h8, ALU_SLT  = 4'h9, ALU_SRA = 4'hA, ALU_AUIPC = 4'hB,
    ALU_SLTU  = 4'hC, ALU_BLT  = 4'hD, ALU_BGE = 4'hE, ALU_LUI   = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       mem_wen;
    logic       wb_sel;
    logic       reg_wb;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic       illegal;
    logic       br_unsigned;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idex_ctrl_t;

  localparam int CTRL_W = $bits(idex_ctrl_t);

  // Shared by OP and OP-IMM; alt picks SUB/SRA and is only meaningful for funct3 0/5
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decode.sv
// Purely combinational RV32I decoder: instruction word to control bundle,
// register-use flags and the sign-extended immediate.
module rv_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic              uses_rs1,
  output logic              uses_rs2,
  output logic [XLEN-1:0]   imm
);

  idex_ctrl_t d;
  logic       bad;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm32;

  assign f3   = instr[14:12];
  assign f7   = instr[31:25];
  assign ctrl = d;
  assign imm  = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  always_comb begin
    d        = '0;
    bad      = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    imm32    = '0;
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.rd     = instr[11:7];
    d.alu_ctrl = ALU_ADD;
    case (instr[6:0])
      OPC_OP: begin
        d.reg_wb   = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        d.alu_ctrl = alu_from_f3(f3, f7[5]);
        bad = !((f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
      end
      OPC_OP_IMM: begin
        d.alu_src  = 1'b1;
        d.reg_wb   = 1'b1;
        uses_rs1   = 1'b1;
        imm32      = {{20{instr[31]}}, instr[31:20]};
        d.alu_ctrl = alu_from_f3(f3, (f3 == F3_SRL_SRA) & instr[30]);
      end
      OPC_LOAD: begin
        d.alu_src      = 1'b1;
        d.wb_sel       = 1'b1;
        d.reg_wb       = 1'b1;
        d.mem_size     = f3[1:0];
        d.mem_unsigned = f3[2];
        uses_rs1       = 1'b1;
        imm32          = {{20{instr[31]}}, instr[31:20]};
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        d.alu_src  = 1'b1;
        d.mem_wen  = 1'b1;
        d.mem_size = f3[1:0];
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        imm32      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        bad = (f3 >= 3'd3);
      end
      OPC_BRANCH: begin
        d.branch      = 1'b1;
        d.br_unsigned = f3[2] & f3[1];
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3)
          F3_BEQ:           d.alu_ctrl = ALU_BEQ;
          F3_BNE:           d.alu_ctrl = ALU_BNE;
          F3_BLT, F3_BLTU:  d.alu_ctrl = ALU_BLT;
          F3_BGE, F3_BGEU:  d.alu_ctrl = ALU_BGE;
          default:          bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        d.jal     = 1'b1;
        d.reg_wb  = 1'b1;
        d.alu_src = 1'b1;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        d.jalr    = 1'b1;
        d.reg_wb  = 1'b1;
        d.alu_src = 1'b1;
        uses_rs1  = 1'b1;
        imm32     = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LUI: begin
        d.alu_ctrl = ALU_LUI;
        d.alu_src  = 1'b1;
        d.reg_wb   = 1'b1;
        imm32      = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        d.alu_ctrl = ALU_AUIPC;
        d.auipc    = 1'b1;
        d.alu_src  = 1'b1;
        d.reg_wb   = 1'b1;
        imm32      = {instr[31:12], 12'b0};
      end
      default: bad = 1'b1;
    endcase
    // Illegal instructions still travel to EX to trap, but must not change state
    if (bad) begin
      d.illegal = 1'b1;
      d.reg_wb  = 1'b0;
      d.mem_wen = 1'b0;
      d.branch  = 1'b0;
      d.jal     = 1'b0;
      d.jalr    = 1'b0;
    end
    if (!d.reg_wb) d.rd = 5'd0;
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID stage: decodes the IF/ID instruction into the ID/EX register with a
// valid/ready handshake, load-use bubble insertion, flush and perf counters.
module id_ctrl_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_ctrl,
  output logic             ex_alu_src,
  output logic             ex_mem_wen,
  output logic             ex_wb_sel,
  output logic             ex_reg_wb,
  output logic             ex_branch,
  output logic             ex_jal,
  output logic             ex_jalr,
  output logic             ex_auipc,
  output logic             ex_illegal,
  output logic             ex_br_unsigned,
  output logic [1:0]       ex_mem_size,
  output logic             ex_mem_unsigned,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_pc,
  output logic [CNT_W-1:0] perf_instr,
  output logic [CNT_W-1:0] perf_stall
);

  logic [CTRL_W-1:0] dec_bits;
  idex_ctrl_t        dec;
  idex_ctrl_t        ex;
  logic              dec_uses_rs1;
  logic              dec_uses_rs2;
  logic [XLEN-1:0]   dec_imm;
  logic              hazard;
  logic              advance;
  logic              issue;
  logic              stall_event;

  rv_decode #(.XLEN(XLEN)) u_decode (
    .instr    (id_instr),
    .ctrl     (dec_bits),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .imm      (dec_imm)
  );

  assign dec = idex_ctrl_t'(dec_bits);

  // A load in EX cannot forward in time to the consumer now in ID
  assign hazard = ex_valid & ex.wb_sel & (ex.rd != 5'd0) &
                  ((dec_uses_rs1 & (dec.rs1 == ex.rd)) |
                   (dec_uses_rs2 & (dec.rs2 == ex.rd)));

  assign advance     = ~ex_valid | ex_ready;
  assign issue       = advance & id_valid & ~flush & ~hazard;
  assign stall_event = advance & id_valid & hazard & ~flush;
  assign id_ready    = ~reset & advance & (flush | ~hazard);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex         <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
      perf_instr <= '0;
      perf_stall <= '0;
    end else begin
      if (advance) begin
        ex_valid <= issue;
        ex       <= issue ? dec : '0;
        ex_imm   <= issue ? dec_imm : '0;
        ex_pc    <= issue ? id_pc : '0;
      end
      if (issue)       perf_instr <= perf_instr + CNT_W'(1);
      if (stall_event) perf_stall <= perf_stall + CNT_W'(1);
    end
  end

  assign ex_alu_ctrl     = ex.alu_ctrl;
  assign ex_alu_src      = ex.alu_src;
  assign ex_mem_wen      = ex.mem_wen;
  assign ex_wb_sel       = ex.wb_sel;
  assign ex_reg_wb       = ex.reg_wb;
  assign ex_branch       = ex.branch;
  assign ex_jal          = ex.jal;
  assign ex_jalr         = ex.jalr;
  assign ex_auipc        = ex.auipc;
  assign ex_illegal      = ex.illegal;
  assign ex_br_unsigned  = ex.br_unsigned;
  assign ex_mem_size     = ex.mem_size;
  assign ex_mem_unsigned = ex.mem_unsigned;
  assign ex_rs1          = ex.rs1;
  assign ex_rs2          = ex.rs2;
  assign ex_rd           = ex.rd;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the stage.
module tb_id_ctrl_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_alu_src, ex_mem_wen, ex_wb_sel, ex_reg_wb, ex_branch;
  logic        ex_jal, ex_jalr, ex_auipc, ex_illegal, ex_br_unsigned;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_pc;
  logic [31:0] perf_instr, perf_stall;

  id_ctrl_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src),
    .ex_mem_wen(ex_mem_wen), .ex_wb_sel(ex_wb_sel), .ex_reg_wb(ex_reg_wb),
    .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_auipc(ex_auipc), .ex_illegal(ex_illegal),
    .ex_br_unsigned(ex_br_unsigned), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .perf_instr(perf_instr), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  // Expected ID/EX contents plus which fields the instruction class defines
  typedef struct packed {
    logic [3:0]  alu;
    logic        alu_src, mem_wen, wb_sel, reg_wb, branch, jal, jalr, auipc;
    logic        illegal, br_uns;
    logic [1:0]  size;
    logic        mem_uns;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
    logic        use1, use2, c_alu, c_imm, c_size, c_uns, full;
  } exp_t;

  int alu_by_f3 [8] = '{0, 5, 9, 12, 2, 6, 3, 4};
  int br_by_f3  [8] = '{7, 8, 0, 0, 13, 14, 13, 14};
  int ld_f3     [5] = '{0, 1, 2, 4, 5};
  int br_f3     [6] = '{0, 1, 4, 5, 6, 7};

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        m;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr_cnt = '0;
  logic [31:0] m_stall_cnt = '0;
  logic        after_rst = 1'b0;
  logic        last_ready;
  logic [31:0] pc_next = 32'h0000_1000;
  logic [31:0] saved_pc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t        e;
    logic [2:0]  f3;
    logic [31:0] sign, iimm, simm, bimm, jimm;
    f3   = w[14:12];
    sign = $signed(w) >>> 31;
    iimm = $signed(w) >>> 20;
    simm = (iimm & ~32'h1F) | 32'(w[11:7]);
    bimm = (sign & 32'hFFFF_F000) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    jimm = (sign & 32'hFFF0_0000) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    e = '0;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.full = 1'b1; e.c_alu = 1'b1; e.c_imm = 1'b1;
    case (w[6:0])
      7'h33: begin
        e.use1 = 1; e.use2 = 1; e.reg_wb = 1; e.c_imm = 0;
        e.alu = 4'(alu_by_f3[f3]);
        if (w[30] && f3 == 0) e.alu = 4'h1;
        if (w[30] && f3 == 5) e.alu = 4'hA;
        e.illegal = !(w[31:25] == 0 || (w[31:25] == 7'h20 && (f3 == 0 || f3 == 5)));
      end
      7'h13: begin
        e.use1 = 1; e.reg_wb = 1; e.alu_src = 1; e.imm = iimm;
        e.alu = (f3 == 5 && w[30]) ? 4'hA : 4'(alu_by_f3[f3]);
      end
      7'h03: begin
        e.use1 = 1; e.reg_wb = 1; e.alu_src = 1; e.wb_sel = 1; e.imm = iimm;
        e.c_size = 1; e.c_uns = 1; e.size = 2'(f3 % 4); e.mem_uns = (f3 >= 4);
        e.illegal = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        e.use1 = 1; e.use2 = 1; e.alu_src = 1; e.mem_wen = 1; e.imm = simm;
        e.c_size = 1; e.size = f3[1:0]; e.illegal = (f3 >= 3);
      end
      7'h63: begin
        e.use1 = 1; e.use2 = 1; e.branch = 1; e.imm = bimm;
        e.alu = 4'(br_by_f3[f3]); e.br_uns = (f3 >= 6);
        e.illegal = (f3 == 2 || f3 == 3);
      end
      7'h6F: begin e.jal  = 1; e.reg_wb = 1; e.alu_src = 1; e.imm = jimm; e.c_alu = 0; end
      7'h67: begin e.jalr = 1; e.reg_wb = 1; e.alu_src = 1; e.use1 = 1; e.imm = iimm; e.c_alu = 0; end
      7'h37: begin e.alu = 4'hF; e.reg_wb = 1; e.alu_src = 1; e.imm = w & 32'hFFFF_F000; end
      7'h17: begin e.alu = 4'hB; e.auipc = 1; e.reg_wb = 1; e.alu_src = 1; e.imm = w & 32'hFFFF_F000; end
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin
      e.reg_wb = 0; e.mem_wen = 0; e.branch = 0; e.jal = 0; e.jalr = 0; e.full = 0;
    end
    if (!e.reg_wb) e.rd = 0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [2:0]  f3;
    int          cls;
    w   = $urandom;
    f3  = 3'($urandom_range(0, 7));
    cls = $urandom_range(0, 8);
    case (cls)
      0: begin
        w[6:0] = 7'h33; w[24:20] = 5'($urandom_range(0, 3));
        w[31:25] = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      1: begin
        w[6:0] = 7'h13;
        if (f3 == 1) w[31:25] = 7'h00;
        if (f3 == 5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      2: begin w[6:0] = 7'h03; f3 = 3'(ld_f3[$urandom_range(0, 4)]); end
      3: begin w[6:0] = 7'h23; f3 = 3'($urandom_range(0, 2)); w[24:20] = 5'($urandom_range(0, 3)); end
      4: begin w[6:0] = 7'h63; f3 = 3'(br_f3[$urandom_range(0, 5)]); w[24:20] = 5'($urandom_range(0, 3)); end
      5: w[6:0] = 7'h6F;
      6: begin w[6:0] = 7'h67; f3 = 3'd0; end
      7: w[6:0] = 7'h37;
      default: w[6:0] = 7'h17;
    endcase
    if (cls != 5 && cls != 7 && cls != 8) begin
      w[14:12] = f3;
      w[19:15] = 5'($urandom_range(0, 3));
    end
    w[11:7] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  task automatic compareState();
    checkOutput("ex_valid", ex_valid, m_valid);
    checkOutput("perf_instr", perf_instr, m_instr_cnt);
    checkOutput("perf_stall", perf_stall, m_stall_cnt);
    if (m_valid) begin
      checkOutput("illegal", ex_illegal, m.illegal);
      checkOutput("reg_wb", ex_reg_wb, m.reg_wb);
      checkOutput("mem_wen", ex_mem_wen, m.mem_wen);
      checkOutput("branch", ex_branch, m.branch);
      checkOutput("jal", ex_jal, m.jal);
      checkOutput("jalr", ex_jalr, m.jalr);
      checkOutput("rd", ex_rd, m.rd);
      checkOutput("pc", ex_pc, m.pc);
      if (m.full) begin
        checkOutput("alu_src", ex_alu_src, m.alu_src);
        checkOutput("wb_sel", ex_wb_sel, m.wb_sel);
        checkOutput("auipc", ex_auipc, m.auipc);
        checkOutput("br_unsigned", ex_br_unsigned, m.br_uns);
        if (m.c_alu)  checkOutput("alu_ctrl", ex_alu_ctrl, m.alu);
        if (m.c_imm)  checkOutput("imm", ex_imm, m.imm);
        if (m.c_size) checkOutput("mem_size", ex_mem_size, m.size);
        if (m.c_uns)  checkOutput("mem_unsigned", ex_mem_unsigned, m.mem_uns);
        if (m.use1)   checkOutput("rs1", ex_rs1, m.rs1);
        if (m.use2)   checkOutput("rs2", ex_rs2, m.rs2);
      end
    end else begin
      checkOutput("bubble_ctrl",
                  {ex_alu_ctrl, ex_alu_src, ex_mem_wen, ex_wb_sel, ex_reg_wb,
                   ex_branch, ex_jal, ex_jalr, ex_auipc, ex_illegal}, 32'd0);
      if (after_rst) begin
        checkOutput("rst_imm", ex_imm, 32'd0);
        checkOutput("rst_pc", ex_pc, 32'd0);
        checkOutput("rst_regs", {ex_rs1, ex_rs2, ex_rd, ex_mem_size,
                                 ex_mem_unsigned, ex_br_unsigned}, 32'd0);
      end
    end
  endtask

  // One clock: drive inputs, check id_ready, advance the model, check ID/EX
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic fl, input logic er, input logic rst);
    exp_t d;
    logic adv, haz, exp_ready;
    @(negedge clk);
    id_valid = v; id_instr = ins; id_pc = pc_next; flush = fl; ex_ready = er; reset = rst;
    #1;
    d   = ref_decode(ins, pc_next);
    adv = !m_valid || er;
    haz = m_valid && m.wb_sel && (m.rd != 0) &&
          ((d.use1 && d.rs1 == m.rd) || (d.use2 && d.rs2 == m.rd));
    exp_ready = !rst && adv && (fl || !haz);
    last_ready = id_ready;
    checkOutput("id_ready", id_ready, exp_ready);
    if (rst) begin
      m_valid = 0; m = '0; m_instr_cnt = 0; m_stall_cnt = 0;
    end else if (adv) begin
      if (fl || !v || haz) begin
        if (v && haz && !fl) m_stall_cnt++;
        m_valid = 0; m = '0;
      end else begin
        m_valid = 1; m = d; m_instr_cnt++;
      end
    end
    after_rst = rst;
    pc_next += 4;
    @(posedge clk);
    #1;
    compareState();
  endtask

  initial begin
    applyStimulus(0, 32'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 0, 1, 1);

    applyStimulus(1, 32'hFFB10093, 0, 1, 0);
    checkOutput("addi_valid", ex_valid, 1);
    checkOutput("addi_alu", ex_alu_ctrl, 4'h0);
    checkOutput("addi_src", ex_alu_src, 1);
    checkOutput("addi_wb", ex_reg_wb, 1);
    checkOutput("addi_imm", ex_imm, 32'hFFFFFFFB);
    checkOutput("addi_rs1", ex_rs1, 5'd2);
    checkOutput("addi_rd", ex_rd, 5'd1);
    checkOutput("addi_cnt", perf_instr, 32'd1);

    applyStimulus(1, 32'h402081B3, 0, 1, 0);
    checkOutput("sub_alu", ex_alu_ctrl, 4'h1);
    checkOutput("sub_src", ex_alu_src, 0);
    applyStimulus(1, 32'h40325213, 0, 1, 0);
    checkOutput("srai_alu", ex_alu_ctrl, 4'hA);
    checkOutput("srai_src", ex_alu_src, 1);
    checkOutput("srai_imm", ex_imm, 32'h00000403);

    applyStimulus(1, 32'h0000A283, 0, 1, 0);
    applyStimulus(1, 32'h00528333, 0, 1, 0);
    checkOutput("lu_ready", last_ready, 0);
    checkOutput("lu_bubble", ex_valid, 0);
    checkOutput("lu_stall", perf_stall, 32'd1);
    applyStimulus(1, 32'h00528333, 0, 1, 0);
    checkOutput("lu_issue", ex_valid, 1);
    checkOutput("lu_rd", ex_rd, 5'd6);

    applyStimulus(1, 32'h0000A003, 0, 1, 0);
    applyStimulus(1, 32'h00000333, 0, 1, 0);
    checkOutput("x0_ready", last_ready, 1);
    checkOutput("x0_valid", ex_valid, 1);
    checkOutput("x0_stall", perf_stall, 32'd1);

    applyStimulus(1, 32'h0000A283, 0, 1, 0);
    applyStimulus(1, 32'h00028463, 1, 1, 0);
    checkOutput("flush_ready", last_ready, 1);
    checkOutput("flush_valid", ex_valid, 0);
    checkOutput("flush_stall", perf_stall, 32'd1);

    saved_pc = pc_next;
    applyStimulus(1, 32'hFFB10093, 0, 1, 0);
    applyStimulus(1, 32'h402081B3, 0, 0, 0);
    checkOutput("hold_ready", last_ready, 0);
    checkOutput("hold_pc", ex_pc, saved_pc);
    checkOutput("hold_imm", ex_imm, 32'hFFFFFFFB);
    applyStimulus(1, 32'h402081B3, 0, 0, 1);
    checkOutput("rst_valid", ex_valid, 0);
    checkOutput("rst_instr", perf_instr, 32'd0);
    applyStimulus(1, 32'h402081B3, 0, 0, 0);

    applyStimulus(1, 32'h0000007F, 0, 1, 0);
    checkOutput("ill_valid", ex_valid, 1);
    checkOutput("ill_flag", ex_illegal, 1);
    checkOutput("ill_wb", ex_reg_wb, 0);
    checkOutput("ill_wen", ex_mem_wen, 0);
    applyStimulus(1, 32'h0000B283, 0, 1, 0);
    checkOutput("illld_valid", ex_valid, 1);
    checkOutput("illld_flag", ex_illegal, 1);
    checkOutput("illld_wb", ex_reg_wb, 0);
    checkOutput("illld_wen", ex_mem_wen, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, gen_instr(),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 63) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered instruction-decode stage for the 5-stage RV32I pipeline. It sits between the IF/ID and ID/EX boundaries and decodes every RV32I opcode class into ALU, memory, branch and writeback controls plus the sign-extended immediate. It registers the results into the ID/EX pipeline register with a valid/ready handshake. It detects load-use hazards and inserts a single bubble, honours branch flushes, and keeps stall/instruction performance counters.

## Interface
- XLEN, 32: datapath width for pc/imm (32 only for RV32I; imm sign-extended to XLEN)
- CNT_W, 32: width of performance counters
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- id_valid  in  1  IF/ID holds an instruction
- id_ready  out  1  stage consumes the IF/ID instruction this cycle
- id_instr  in  32  instruction word
- id_pc  in  XLEN  its PC
- flush  in  1  kill the instruction in ID (taken branch/jump resolved in EX)
- ex_ready  in  1  EX accepts the ID/EX register contents
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_alu_ctrl  out  4  0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 BEQ, 8 BNE, 9 SLT, A SRA, B AUIPC, C SLTU, D BLT, E BGE, F LUI-pass
- ex_alu_src, ex_mem_wen, ex_wb_sel, ex_reg_wb, ex_branch, ex_jal, ex_jalr, ex_auipc, ex_illegal  out  1 each  decoded controls
- ex_br_unsigned  out  1  BLTU/BGEU (uses codes D/E)
- ex_mem_size  out  2  0 byte, 1 half, 2 word
- ex_mem_unsigned  out  1  LBU/LHU
- ex_imm  out  XLEN  I/S/B/U/J immediate, selected by opcode
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices (rd forced 0 when ex_reg_wb=0)
- ex_pc  out  XLEN  PC of the instruction
- perf_instr, perf_stall  out  CNT_W each  instructions issued to EX; bubble cycles inserted by hazard

## Operation
- Combinational decode of id_instr. R: alu_src=0, reg_wb=1; funct7[5] selects SUB/SRA. OP-IMM: alu_src=1, reg_wb=1; SRAI when instr[30]=1; SUB never produced. LOAD: alu ADD, alu_src=1, wb_sel=1, reg_wb=1, size/unsigned from funct3. STORE: alu ADD, alu_src=1, mem_wen=1. BRANCH: branch=1, alu_src=0, codes 7/8/D/E, br_unsigned for funct3 6/7. JAL/JALR: jal/jalr=1, reg_wb=1, alu_src=1. LUI: code F, alu_src=1, reg_wb=1. AUIPC: code B, auipc=1.
- Illegal: unknown opcode, LOAD funct3 3/6/7, STORE funct3 ≥3, BRANCH funct3 2/3, or an R-type funct7 other than 0x00/0x20 (0x20 only for funct3 0/5). Result: illegal=1 and all of reg_wb, mem_wen, branch, jal, jalr = 0. The instruction is still issued so EX can trap.
- Uses rs1: all classes except LUI/AUIPC/JAL. Uses rs2: R, STORE, BRANCH.
- Hazard = ex_valid & ex_wb_sel & ex_rd≠0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- advance = ~ex_valid | ex_ready.
- id_ready = advance & (flush | ~hazard).
- On advance: if flush, or ~id_valid, or hazard, then ex_valid←0 (bubble; control fields zeroed). Otherwise load all decoded fields and set ex_valid←1.
- Without advance: the ID/EX register holds all values; id_ready=0.
- Priority: reset > flush > hazard > normal. Flush with id_valid=1 consumes and discards the instruction.
- perf_instr increments when a valid instruction is loaded. perf_stall increments when advance & id_valid & hazard & ~flush. Both wrap at 2^CNT_W.

## Timing
- Decode-to-EX latency: 1 cycle. id_ready is combinational from inputs and ID/EX state.
- Reset (synchronous, 1 cycle minimum): ex_valid=0, every ex_* output 0, perf counters 0, id_ready=0 while reset is high. Reset mid-stall discards the held instruction.
- Load-use: exactly one bubble cycle. The following cycle ex_valid=0 on the bubble, so the hazard clears and the instruction is accepted.
- Back-to-back issue at 1 instruction/cycle when ex_ready=1 and there is no hazard.

## Structure
- Shared package riscv_pkg: opcode constants, funct3 values, the ALU code set above, and mem_size encoding; existing riscv_defs constants move there.
- Sub-module rv_decode: purely combinational instr → control bundle, uses_rs1/uses_rs2, illegal flag, and immediate. id_ctrl_stage contains the handshake, hazard, flush, ID/EX register and counters.

## Test plan
- addi x1,x2,-5 (0xFFB10093), ex_ready=1 → next cycle ex_valid=1, alu_ctrl=0, alu_src=1, reg_wb=1, imm=0xFFFFFFFB, rs1=2, rd=1; perf_instr=1.
- sub x3,x1,x2 (0x402081B3) then srai x4,x4,3 (0x40325213) → alu_ctrl 1 then A, alu_src 0 then 1, imm=0x403.
- lw x5,0(x1) (0x0000A283) followed by add x6,x5,x5 (0x00528333) → id_ready=0 for one cycle, one bubble (ex_valid=0), add issues the cycle after, perf_stall=1. The same pair with rd=x0 produces no stall.
- flush asserted with a beq in ID while a hazard is also present → id_ready=1, ex_valid=0 next cycle, perf_stall unchanged.
- ex_ready=0 for 3 cycles with a valid instruction in ID/EX → all ex_* outputs stable, id_ready=0. Reset asserted in the 2nd cycle → all outputs and counters 0 the next cycle.
- Opcode 0x7F, and LOAD with funct3=3 → ex_valid=1, illegal=1, reg_wb=0, mem_wen=0.
